// File: rtl/stochastic_search_sequencer.sv
// -----------------------------------------------------------------------------
// stochastic_search_sequencer
//
// Sits between the host configuration path and the StochasticSearch engine.
// In IDLE it accepts clause beats and puts each one on the engine clause write
// port for one cycle. It also keeps a mask of which clauses have been written.
// On start it seeds the engine's assignment and runs bounded search
// iterations. Each iteration's best assignment is fed back as the next
// starting point. The block keeps the best result seen and stops early once
// every existing clause is satisfied.
//
// Ports
//   in_clk / in_reset             clock, synchronous active-high reset
//   in_cfg_*  / out_cfg_ready     clause beat handshake, index, coefficients,
//                                 mask flush
//   in_start, in_abort            search control
//   in_iteration_limit            iteration budget, latched at start
//   in_seed_*                     initial assignment
//   out_engine_*                  enable, clause write port, clause mask,
//                                 current assignment
//   in_engine_*                   engine ready, best gain, best assignment
//   out_busy/out_done/out_solved  status
//   out_iterations, out_best_*    completed iterations and best result
// -----------------------------------------------------------------------------
module stochastic_search_sequencer #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT     = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT     = 2,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX  = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX  = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE        = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX           = 2,
    parameter int MAXIMUM_BIT_WIDTH_OF_ITERATION_COUNT         = 8,
    localparam int IC = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
    localparam int BC = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT,
    localparam int NI = 2 ** MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
    localparam int NB = 2 ** MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
    localparam int IV = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE,
    localparam int CW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
    localparam int NC = 2 ** MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
    localparam int IW = MAXIMUM_BIT_WIDTH_OF_ITERATION_COUNT
) (
    input  logic                  in_clk,
    input  logic                  in_reset,
    input  logic                  in_cfg_valid,
    output logic                  out_cfg_ready,
    input  logic [CW-1:0]         in_cfg_index,
    input  logic [(NI+1)*IC-1:0]  in_cfg_coefficients_integer,
    input  logic [BC*NB-1:0]      in_cfg_coefficients_boolean,
    input  logic                  in_cfg_flush,
    input  logic                  in_start,
    input  logic                  in_abort,
    input  logic [IW-1:0]         in_iteration_limit,
    input  logic [NI*IV-1:0]      in_seed_integer,
    input  logic [NB-1:0]         in_seed_boolean,
    output logic                  out_engine_enable,
    output logic [CW-1:0]         out_engine_clause_index,
    output logic [(NI+1)*IC-1:0]  out_engine_coefficients_integer,
    output logic [BC*NB-1:0]      out_engine_coefficients_boolean,
    output logic [NC-1:0]         out_engine_existing_clauses,
    output logic [NI*IV-1:0]      out_engine_integer_assignments,
    output logic [NB-1:0]         out_engine_boolean_assignments,
    input  logic                  in_engine_ready,
    input  logic [CW:0]           in_engine_bestgain,
    input  logic [NI*IV-1:0]      in_engine_best_integer,
    input  logic [NB-1:0]         in_engine_best_boolean,
    output logic                  out_busy,
    output logic                  out_done,
    output logic                  out_solved,
    output logic [IW-1:0]         out_iterations,
    output logic [CW:0]           out_best_gain,
    output logic [NI*IV-1:0]      out_best_integer,
    output logic [NB-1:0]         out_best_boolean
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RUN     = 3'd2,
        S_RESTART = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          eng_index_q, eng_index_d;
    logic [(NI+1)*IC-1:0]   eng_coef_int_q, eng_coef_int_d;
    logic [BC*NB-1:0]       eng_coef_bool_q, eng_coef_bool_d;
    logic [NC-1:0]          mask_q, mask_d;
    logic [NI*IV-1:0]       assign_int_q, assign_int_d;
    logic [NB-1:0]          assign_bool_q, assign_bool_d;
    logic [IW-1:0]          iterations_q, iterations_d;
    logic [IW-1:0]          limit_q, limit_d;
    logic [CW:0]            best_gain_q, best_gain_d;
    logic [NI*IV-1:0]       best_int_q, best_int_d;
    logic [NB-1:0]          best_bool_q, best_bool_d;
    logic                   solved_q, solved_d;

    // The popcount is one bit wider than the clause index, so a full mask
    // (NC clauses) is representable and compares directly against the gain.
    logic [CW:0]            popcount;
    logic [IW-1:0]          iter_inc;

    always_comb begin
        popcount = '0;
        for (int i = 0; i < NC; i++) begin
            popcount = popcount + {{CW{1'b0}}, mask_q[i]};
        end
    end

    assign iter_inc = iterations_q + {{(IW-1){1'b0}}, 1'b1};

    // State and datapath registers
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q         <= S_IDLE;
            eng_index_q     <= '0;
            eng_coef_int_q  <= '0;
            eng_coef_bool_q <= '0;
            mask_q          <= '0;
            assign_int_q    <= '0;
            assign_bool_q   <= '0;
            iterations_q    <= '0;
            limit_q         <= '0;
            best_gain_q     <= '0;
            best_int_q      <= '0;
            best_bool_q     <= '0;
            solved_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            eng_index_q     <= eng_index_d;
            eng_coef_int_q  <= eng_coef_int_d;
            eng_coef_bool_q <= eng_coef_bool_d;
            mask_q          <= mask_d;
            assign_int_q    <= assign_int_d;
            assign_bool_q   <= assign_bool_d;
            iterations_q    <= iterations_d;
            limit_q         <= limit_d;
            best_gain_q     <= best_gain_d;
            best_int_q      <= best_int_d;
            best_bool_q     <= best_bool_d;
            solved_q        <= solved_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d         = state_q;
        eng_index_d     = eng_index_q;
        eng_coef_int_d  = eng_coef_int_q;
        eng_coef_bool_d = eng_coef_bool_q;
        mask_d          = mask_q;
        assign_int_d    = assign_int_q;
        assign_bool_d   = assign_bool_q;
        iterations_d    = iterations_q;
        limit_d         = limit_q;
        best_gain_d     = best_gain_q;
        best_int_d      = best_int_q;
        best_bool_d     = best_bool_q;
        solved_d        = solved_q;

        case (state_q)
            S_IDLE: begin
                // A cfg beat wins over flush and start. The losing request is
                // dropped, and the host re-presents it.
                if (in_cfg_valid) begin
                    eng_index_d          = in_cfg_index;
                    eng_coef_int_d       = in_cfg_coefficients_integer;
                    eng_coef_bool_d      = in_cfg_coefficients_boolean;
                    mask_d[in_cfg_index] = 1'b1;
                    state_d              = S_WRITE;
                end else if (in_cfg_flush) begin
                    mask_d = '0;
                end else if (in_start) begin
                    iterations_d = '0;
                    best_gain_d  = '0;
                    best_int_d   = '0;
                    best_bool_d  = '0;
                    limit_d      = in_iteration_limit;
                    if (mask_q == '0) begin
                        // No clauses exist, so the formula is trivially solved.
                        solved_d = 1'b1;
                        state_d  = S_DONE;
                    end else if (in_iteration_limit == '0) begin
                        solved_d = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        assign_int_d  = in_seed_integer;
                        assign_bool_d = in_seed_boolean;
                        solved_d      = 1'b0;
                        state_d       = S_RUN;
                    end
                end
            end

            S_WRITE: begin
                state_d = S_IDLE;
            end

            S_RUN: begin
                // Abort takes precedence, and a same-cycle ready is discarded.
                if (in_abort) begin
                    solved_d = 1'b0;
                    state_d  = S_DONE;
                end else if (in_engine_ready) begin
                    iterations_d = iter_inc;
                    if (iterations_q == '0 || in_engine_bestgain > best_gain_q) begin
                        best_gain_d = in_engine_bestgain;
                        best_int_d  = in_engine_best_integer;
                        best_bool_d = in_engine_best_boolean;
                    end
                    assign_int_d  = in_engine_best_integer;
                    assign_bool_d = in_engine_best_boolean;
                    if (in_engine_bestgain == popcount) begin
                        solved_d = 1'b1;
                        state_d  = S_DONE;
                    end else if (iter_inc == limit_q) begin
                        solved_d = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_RESTART;
                    end
                end
            end

            S_RESTART: begin
                if (in_abort) begin
                    solved_d = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        out_cfg_ready     = (state_q == S_IDLE);
        out_engine_enable = (state_q == S_RUN);
        out_busy          = (state_q == S_RUN) || (state_q == S_RESTART);
        out_done          = (state_q == S_DONE);
    end

    assign out_engine_clause_index         = eng_index_q;
    assign out_engine_coefficients_integer = eng_coef_int_q;
    assign out_engine_coefficients_boolean = eng_coef_bool_q;
    assign out_engine_existing_clauses     = mask_q;
    assign out_engine_integer_assignments  = assign_int_q;
    assign out_engine_boolean_assignments  = assign_bool_q;
    assign out_solved                      = solved_q;
    assign out_iterations                  = iterations_q;
    assign out_best_gain                   = best_gain_q;
    assign out_best_integer                = best_int_q;
    assign out_best_boolean                = best_bool_q;

endmodule

// File: tb/tb_stochastic_search_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for stochastic_search_sequencer. The configuration beats and the
// search runs come from vector tables. Hand-written sequences cover the
// immediate-DONE starts, the cfg/start priority and reset during RUN.
// Inputs change on the falling edge, and outputs are checked there.
// -----------------------------------------------------------------------------
module tb_stochastic_search_sequencer;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_index;
    logic [11:0] cfg_ci;
    logic [3:0]  cfg_cb;
    logic        cfg_flush;
    logic        start;
    logic        abort_s;
    logic [7:0]  limit;
    logic [7:0]  seed_int;
    logic [1:0]  seed_bool;
    logic        eng_en;
    logic [1:0]  eng_idx;
    logic [11:0] eng_ci;
    logic [3:0]  eng_cb;
    logic [3:0]  eng_mask;
    logic [7:0]  eng_ai;
    logic [1:0]  eng_ab;
    logic        eng_ready;
    logic [2:0]  eng_gain;
    logic [7:0]  eng_bi;
    logic [1:0]  eng_bb;
    logic        busy;
    logic        done;
    logic        solved;
    logic [7:0]  iters;
    logic [2:0]  best_gain;
    logic [7:0]  best_int;
    logic [1:0]  best_bool;

    int checks = 0;
    int errors = 0;

    stochastic_search_sequencer dut (
        .in_clk                          (clk),
        .in_reset                        (rst),
        .in_cfg_valid                    (cfg_valid),
        .out_cfg_ready                   (cfg_ready),
        .in_cfg_index                    (cfg_index),
        .in_cfg_coefficients_integer     (cfg_ci),
        .in_cfg_coefficients_boolean     (cfg_cb),
        .in_cfg_flush                    (cfg_flush),
        .in_start                        (start),
        .in_abort                        (abort_s),
        .in_iteration_limit              (limit),
        .in_seed_integer                 (seed_int),
        .in_seed_boolean                 (seed_bool),
        .out_engine_enable               (eng_en),
        .out_engine_clause_index         (eng_idx),
        .out_engine_coefficients_integer (eng_ci),
        .out_engine_coefficients_boolean (eng_cb),
        .out_engine_existing_clauses     (eng_mask),
        .out_engine_integer_assignments  (eng_ai),
        .out_engine_boolean_assignments  (eng_ab),
        .in_engine_ready                 (eng_ready),
        .in_engine_bestgain              (eng_gain),
        .in_engine_best_integer          (eng_bi),
        .in_engine_best_boolean          (eng_bb),
        .out_busy                        (busy),
        .out_done                        (done),
        .out_solved                      (solved),
        .out_iterations                  (iters),
        .out_best_gain                   (best_gain),
        .out_best_integer                (best_int),
        .out_best_boolean                (best_bool)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  idx;
        logic [11:0] ci;
        logic [3:0]  cb;
        logic [3:0]  exp_mask;
    } cfg_vec_t;

    typedef struct {
        logic [7:0]       limit;
        logic [2:0][2:0]  gain;       // gain[i] is returned on ready number i
        int               n_ready;
        bit               abort_last; // abort asserted with the last ready
        logic [7:0]       exp_iters;
        logic             exp_solved;
        logic [2:0]       exp_gain;
        logic [7:0]       exp_bint;
        logic [1:0]       exp_bbool;
    } run_vec_t;

    cfg_vec_t   cfg_tab [4];
    run_vec_t   run_tab [3];
    logic [7:0] stub_bint  [3];
    logic [1:0] stub_bbool [3];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        // Stub engine results for iterations 0, 1 and 2
        stub_bint[0] = 8'hA1; stub_bbool[0] = 2'b01;
        stub_bint[1] = 8'hB2; stub_bbool[1] = 2'b10;
        stub_bint[2] = 8'hC3; stub_bbool[2] = 2'b11;

        cfg_tab[0] = '{2'd0, 12'h411, 4'b1111, 4'b0001};
        cfg_tab[1] = '{2'd1, 12'h511, 4'b1011, 4'b0011};
        cfg_tab[2] = '{2'd2, 12'h611, 4'b1011, 4'b0111};
        cfg_tab[3] = '{2'd3, 12'h311, 4'hF,    4'b1111};

        // Gains are packed with element 2 first: {g2, g1, g0}
        run_tab[0] = '{8'd5, {3'd4, 3'd1, 3'd2}, 3, 1'b0, 8'd3, 1'b1, 3'd4, 8'hC3, 2'b11};
        run_tab[1] = '{8'd3, {3'd2, 3'd3, 3'd1}, 3, 1'b0, 8'd3, 1'b0, 3'd3, 8'hB2, 2'b10};
        run_tab[2] = '{8'd5, {3'd0, 3'd2, 3'd1}, 2, 1'b1, 8'd1, 1'b0, 3'd1, 8'hA1, 2'b01};

        rst = 1'b1; cfg_valid = 1'b0; cfg_index = '0; cfg_ci = '0; cfg_cb = '0;
        cfg_flush = 1'b0; start = 1'b0; abort_s = 1'b0; limit = '0;
        seed_int = '0; seed_bool = '0; eng_ready = 1'b0; eng_gain = '0;
        eng_bi = '0; eng_bb = '0;
        tick; tick;
        rst = 1'b0;
        tick;

        // Reset state
        chk("reset cfg_ready", cfg_ready, 1);
        chk("reset mask", eng_mask, 0);
        chk("reset enable", eng_en, 0);
        chk("reset done", done, 0);
        chk("reset solved", solved, 0);
        chk("reset iters", iters, 0);
        chk("reset best_gain", best_gain, 0);
        chk("reset assign", {eng_ai, eng_ab}, 0);
        $display("reset: cfg_ready=%0d mask=%0h", cfg_ready, eng_mask);

        // Clause beats
        for (int v = 0; v < 4; v++) begin
            chk("cfg ready before beat", cfg_ready, 1);
            cfg_valid = 1'b1; cfg_index = cfg_tab[v].idx;
            cfg_ci = cfg_tab[v].ci; cfg_cb = cfg_tab[v].cb;
            tick;
            cfg_valid = 1'b0;
            chk("write port index", eng_idx, cfg_tab[v].idx);
            chk("write port coef_int", eng_ci, cfg_tab[v].ci);
            chk("write port coef_bool", eng_cb, cfg_tab[v].cb);
            chk("write enable low", eng_en, 0);
            chk("write cfg_ready low", cfg_ready, 0);
            chk("write mask", eng_mask, cfg_tab[v].exp_mask);
            tick;
            chk("cfg ready after write", cfg_ready, 1);
            $display("cfg beat %0d: idx=%0d ci=%03h cb=%0h mask=%0h", v, cfg_tab[v].idx,
                     cfg_tab[v].ci, cfg_tab[v].cb, eng_mask);
        end

        // Search runs against a stub engine that answers after one idle RUN cycle
        for (int v = 0; v < 3; v++) begin
            start = 1'b1; limit = run_tab[v].limit; seed_int = 8'h11; seed_bool = 2'b10;
            tick;
            start = 1'b0;
            chk("run enable at start", eng_en, 1);
            chk("run busy at start", busy, 1);
            chk("run seed int", eng_ai, 8'h11);
            chk("run seed bool", eng_ab, 2'b10);
            for (int i = 0; i < run_tab[v].n_ready; i++) begin
                tick;
                chk("run waits for ready", eng_en, 1);
                eng_ready = 1'b1; eng_gain = run_tab[v].gain[i];
                eng_bi = stub_bint[i]; eng_bb = stub_bbool[i];
                abort_s = run_tab[v].abort_last && (i == run_tab[v].n_ready - 1);
                tick;
                eng_ready = 1'b0; abort_s = 1'b0;
                if (i == run_tab[v].n_ready - 1) begin
                    chk("run done pulse", done, 1);
                    chk("run done enable", eng_en, 0);
                    chk("run iters", iters, run_tab[v].exp_iters);
                    chk("run solved", solved, run_tab[v].exp_solved);
                    chk("run best_gain", best_gain, run_tab[v].exp_gain);
                    chk("run best_int", best_int, run_tab[v].exp_bint);
                    chk("run best_bool", best_bool, run_tab[v].exp_bbool);
                    tick;
                    chk("run done one cycle", done, 0);
                    chk("run idle cfg_ready", cfg_ready, 1);
                    chk("run iters held", iters, run_tab[v].exp_iters);
                end else begin
                    chk("restart enable gap", eng_en, 0);
                    chk("restart busy", busy, 1);
                    chk("restart no done", done, 0);
                    tick;
                    chk("rerun enable", eng_en, 1);
                    chk("rerun assign int", eng_ai, stub_bint[i]);
                    chk("rerun assign bool", eng_ab, stub_bbool[i]);
                end
            end
            $display("run %0d: limit=%0d iters=%0d solved=%0d best_gain=%0d best_int=%02h",
                     v, run_tab[v].limit, iters, solved, best_gain, best_int);
        end

        // Limit 0 on a loaded mask: immediate DONE, not solved
        start = 1'b1; limit = 8'd0;
        tick;
        start = 1'b0;
        chk("limit0 done", done, 1);
        chk("limit0 solved", solved, 0);
        chk("limit0 iters", iters, 0);
        chk("limit0 enable", eng_en, 0);
        tick;
        chk("limit0 done one cycle", done, 0);
        $display("limit0 start: solved=%0d iters=%0d", solved, iters);

        // Flush then start: empty mask is trivially solved
        cfg_flush = 1'b1;
        tick;
        cfg_flush = 1'b0;
        chk("flush mask", eng_mask, 0);
        start = 1'b1; limit = 8'd5;
        tick;
        start = 1'b0;
        chk("empty done", done, 1);
        chk("empty solved", solved, 1);
        chk("empty iters", iters, 0);
        tick;
        $display("flush+start: solved=%0d iters=%0d", solved, iters);

        // Cfg beat and start together: beat wins, start dropped
        cfg_valid = 1'b1; cfg_index = 2'd2; cfg_ci = 12'h611; cfg_cb = 4'b1011;
        start = 1'b1;
        tick;
        cfg_valid = 1'b0; start = 1'b0;
        chk("prio write state", cfg_ready, 0);
        chk("prio no run", busy, 0);
        chk("prio mask", eng_mask, 4'b0100);
        tick;
        chk("prio back idle", cfg_ready, 1);
        chk("prio still not busy", busy, 0);
        chk("prio no done", done, 0);
        $display("cfg+start: mask=%0h busy=%0d", eng_mask, busy);

        // Reset during RUN
        start = 1'b1; limit = 8'd5; seed_int = 8'h5A; seed_bool = 2'b01;
        tick;
        start = 1'b0;
        chk("pre-reset busy", busy, 1);
        rst = 1'b1;
        tick;
        chk("midrun reset busy", busy, 0);
        chk("midrun reset enable", eng_en, 0);
        chk("midrun reset mask", eng_mask, 0);
        chk("midrun reset assign", {eng_ai, eng_ab}, 0);
        chk("midrun reset cfg_ready", cfg_ready, 1);
        chk("midrun reset results", {iters, best_gain, best_int, best_bool, solved, done}, 0);
        rst = 1'b0;
        tick;
        $display("reset in RUN: busy=%0d mask=%0h cfg_ready=%0d", busy, eng_mask, cfg_ready);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
